// File: rtl/pmbist_ucode_engine.sv
// Microcode execution engine for the programmable memory BIST controller.
// Holds a scan-loaded program (slots 0..14, slot 15 is a hardwired NOP),
// steps it while run is high, and drives address, background data and
// memory strobes. Handshake: none; one memory operation is issued per clock
// while run=1 and the registered outputs trail the executing pc by one cycle.
module pmbist_ucode_engine #(
  parameter int INST_NUM = 16,
  parameter int ADDR_X   = 2,
  parameter int ADDR_Y   = 2,
  parameter int BG_DATA  = 2,
  parameter int LOOP_NUM = 4,
  parameter int INST_W   = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_setup,
  input  logic               si,
  output logic               so,
  input  logic               run,
  output logic               end_of_prog,
  output logic [1:0]         op_cmd,
  output logic [ADDR_X-1:0]  addr_x,
  output logic [ADDR_Y-1:0]  addr_y,
  output logic [BG_DATA-1:0] data,
  output logic               cs,
  output logic               we,
  output logic               re,
  output logic               oe,
  output logic               odd_bwe,
  output logic               even_bwe,
  output logic               comp_en
);

  localparam int CHAIN_W = (INST_NUM - 1) * INST_W;
  localparam int PC_W    = $clog2(INST_NUM);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(INST_NUM - 1);

  localparam logic [1:0] OP_NOP = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2;
  localparam logic [1:0] CMD_KEEP = 2'd0, CMD_CHG = 2'd1, CMD_INC = 2'd2, CMD_DEC = 2'd3;
  localparam logic [1:0] LM_JUMP = 2'd1, LM_REPEAT = 2'd2;
  localparam logic [2:0] AA_B = 3'd1, AA_A2B = 3'd2, AA_B2A = 3'd3, AA_XOR = 3'd6;

  logic [CHAIN_W-1:0]  chain;
  logic [PC_W-1:0]     pc, pc_next, pc_inc;
  logic [3:0]          rc, rc_next;
  logic [ADDR_X-1:0]   ax, bx, ax_next, bx_next, cur_x, step_x, new_x, out_x;
  logic [ADDR_Y-1:0]   ay, by, ay_next, by_next, cur_y, step_y, new_y, out_y;
  logic [LOOP_NUM-1:0] loop_flag, loop_flag_next;
  logic                inv_dat, inv_adr, inv_dat_next, inv_adr_next;
  logic [INST_W-1:0]   inst;
  logic [1:0]          xe, ye;
  logic                x_end, y_end, x_wrap, y_wrap, met, data_bit;
  logic [BG_DATA-1:0]  data_next;

  // Field aliases of the instruction being executed.
  logic [1:0] f_op, f_bg, f_xc, f_yc, f_lm, f_lr;
  logic [2:0] f_aa, f_cond;
  logic       f_bgi, f_nlc, f_rci, f_ias, f_idb;
  logic [3:0] f_jmp;
  assign {f_op, f_bg, f_bgi, f_xc, f_yc, f_aa, f_nlc, f_rci, f_cond,
          f_lm, f_lr, f_ias, f_idb, f_jmp} = inst;

  // Swaps INC/DEC while the address sequence is inverted.
  function automatic logic [1:0] eff_cmd(input logic [1:0] cmd, input logic inv);
    if (inv && cmd == CMD_INC) return CMD_DEC;
    if (inv && cmd == CMD_DEC) return CMD_INC;
    return cmd;
  endfunction

  assign so          = chain[0];
  assign end_of_prog = (pc == LAST_PC);
  assign pc_inc      = (pc == LAST_PC) ? pc : pc + 1'b1;

  // Program scan chain: si enters the top of slot 14, so leaves slot 0 bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else if (shift_setup) chain <= {si, chain[CHAIN_W-1:1]};
  end

  // Instruction fetch; pc 15 reads as an all-zero NOP.
  always_comb begin
    inst = '0;
    for (int i = 0; i < INST_NUM - 1; i++)
      if (pc == PC_W'(i)) inst = chain[i*INST_W +: INST_W];
  end

  // Address datapath: selected register, end/wrap flags, condition and step.
  always_comb begin
    cur_x  = (f_aa == AA_B || f_aa == AA_B2A) ? bx : ax;
    cur_y  = (f_aa == AA_B || f_aa == AA_B2A) ? by : ay;
    xe     = eff_cmd(f_xc, inv_adr);
    ye     = eff_cmd(f_yc, inv_adr);
    x_end  = (xe == CMD_DEC) ? ~|cur_x : &cur_x;
    y_end  = (ye == CMD_DEC) ? ~|cur_y : &cur_y;
    x_wrap = (xe == CMD_INC && &cur_x) || (xe == CMD_DEC && ~|cur_x);
    y_wrap = (ye == CMD_INC && &cur_y) || (ye == CMD_DEC && ~|cur_y);
    met    = (~f_cond[2] | x_end) & (~f_cond[1] | y_end) & (~f_cond[0] | (rc == 4'hF));
    case (xe)
      CMD_INC: step_x = cur_x + 1'b1;
      CMD_DEC: step_x = cur_x - 1'b1;
      CMD_CHG: step_x = y_wrap ? cur_x + 1'b1 : cur_x;
      default: step_x = cur_x;
    endcase
    case (ye)
      CMD_INC: step_y = cur_y + 1'b1;
      CMD_DEC: step_y = cur_y - 1'b1;
      CMD_CHG: step_y = x_wrap ? cur_y + 1'b1 : cur_y;
      default: step_y = cur_y;
    endcase
    new_x = (met && f_nlc) ? cur_x : step_x;
    new_y = (met && f_nlc) ? cur_y : step_y;
    out_x = (f_aa == AA_XOR) ? (ax ^ bx) : cur_x;
    out_y = (f_aa == AA_XOR) ? (ay ^ by) : cur_y;
    case (f_bg)
      2'd1:    data_bit = out_x[0] ^ out_y[0];
      2'd2:    data_bit = out_x[0];
      2'd3:    data_bit = out_y[0];
      default: data_bit = 1'b0;
    endcase
    data_next = {BG_DATA{data_bit ^ f_bgi ^ inv_dat}};
  end

  // Next state: address registers, sequencer pc, repeat counter, loop flags.
  always_comb begin
    ax_next = ax; ay_next = ay; bx_next = bx; by_next = by;
    loop_flag_next = loop_flag;
    inv_dat_next = inv_dat;
    inv_adr_next = inv_adr;
    pc_next = pc;
    case (f_aa)
      AA_B:    begin bx_next = new_x; by_next = new_y; end
      AA_B2A:  begin bx_next = new_x; by_next = new_y; ax_next = new_x; ay_next = new_y; end
      AA_A2B:  begin ax_next = new_x; ay_next = new_y; bx_next = new_x; by_next = new_y; end
      default: begin ax_next = new_x; ay_next = new_y; end
    endcase
    case (f_lm)
      LM_JUMP: pc_next = met ? pc_inc : f_jmp;
      LM_REPEAT: begin
        if (met) begin
          loop_flag_next[f_lr] = ~loop_flag[f_lr];
          if (f_idb) inv_dat_next = ~inv_dat;
          if (f_ias) inv_adr_next = ~inv_adr;
          pc_next = loop_flag[f_lr] ? pc_inc : f_jmp;
        end
      end
      default: if (met) pc_next = pc_inc;
    endcase
    if (pc_next != pc) rc_next = 4'd0;
    else if (f_rci)    rc_next = rc + 1'b1;
    else               rc_next = rc;
  end

  // Sequencer state register; run low parks everything at its start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !run) begin
      pc <= '0; rc <= '0; ax <= '0; ay <= '0; bx <= '0; by <= '0;
      loop_flag <= '0; inv_dat <= 1'b0; inv_adr <= 1'b0;
    end else begin
      pc <= pc_next; rc <= rc_next;
      ax <= ax_next; ay <= ay_next; bx <= bx_next; by <= by_next;
      loop_flag <= loop_flag_next; inv_dat <= inv_dat_next; inv_adr <= inv_adr_next;
    end
  end

  // Registered memory operation, address, data and compare enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cmd <= OP_NOP; addr_x <= '0; addr_y <= '0; data <= '0; comp_en <= 1'b0;
    end else begin
      comp_en <= (op_cmd == OP_READ);
      if (run) begin
        op_cmd <= f_op; addr_x <= out_x; addr_y <= out_y; data <= data_next;
      end else begin
        op_cmd <= OP_NOP;
      end
    end
  end

  // Memory strobes decoded from the registered operation.
  always_comb begin
    cs = 1'b0; we = 1'b0; re = 1'b0; oe = 1'b0; odd_bwe = 1'b0; even_bwe = 1'b0;
    case (op_cmd)
      OP_WRITE: begin cs = 1'b1; we = 1'b1; odd_bwe = 1'b1; even_bwe = 1'b1; end
      OP_READ:  begin cs = 1'b1; re = 1'b1; oe = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmbist_ucode_engine.sv
// Directed bench for pmbist_ucode_engine: loads programs over the scan
// chain, runs them and compares every output cycle against hand-built
// expected sequences.
module tb_pmbist_ucode_engine;

  localparam logic [1:0] NOP = 2'd0, WR = 2'd1, RD = 2'd2;
  localparam logic [1:0] AL = 2'd0, CB = 2'd1;
  localparam logic [1:0] KEEP = 2'd0, CHG = 2'd1, INC = 2'd2, DEC = 2'd3;
  localparam logic [1:0] NO_LOOP = 2'd0, JUMP = 2'd1, REPEAT = 2'd2;

  logic       clk, rst, shift_setup, si, run;
  logic       so, end_of_prog, cs, we, re, oe, odd_bwe, even_bwe, comp_en;
  logic [1:0] op_cmd, addr_x, addr_y, data;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;
  logic [15:0]  exp_q[$];
  logic [1:0]   last_op;
  logic [404:0] img;
  logic [404:0] rb;

  pmbist_ucode_engine dut (
    .clk(clk), .rst(rst), .shift_setup(shift_setup), .si(si), .so(so),
    .run(run), .end_of_prog(end_of_prog), .op_cmd(op_cmd),
    .addr_x(addr_x), .addr_y(addr_y), .data(data),
    .cs(cs), .we(we), .re(re), .oe(oe),
    .odd_bwe(odd_bwe), .even_bwe(even_bwe), .comp_en(comp_en)
  );

  assign obs = {end_of_prog, op_cmd, addr_x, addr_y, data,
                cs, we, re, oe, odd_bwe, even_bwe, comp_en};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [26:0] mk_inst(
    input logic [1:0] op, input logic [1:0] bg, input logic bgi,
    input logic [1:0] xc, input logic [1:0] yc, input logic [2:0] aa,
    input logic nlc, input logic rci, input logic [2:0] cnd,
    input logic [1:0] lm, input logic [1:0] lr, input logic ias,
    input logic idb, input logic [3:0] jmp);
    return {op, bg, bgi, xc, yc, aa, nlc, rci, cnd, lm, lr, ias, idb, jmp};
  endfunction

  // scoreboard: expected output word for one clock
  task automatic push_exp(input logic [1:0] op, input logic [1:0] x,
                          input logic [1:0] y, input logic d, input logic eop);
    logic cs_e, we_e, re_e, cmp_e;
    cs_e  = (op == WR) || (op == RD);
    we_e  = (op == WR);
    re_e  = (op == RD);
    cmp_e = (last_op == RD);
    exp_q.push_back({eop, op, x, y, {2{d}}, cs_e, we_e, re_e, re_e, we_e, we_e, cmp_e});
    last_op = op;
  endtask

  task automatic push_nops(input int n, input logic [1:0] x, input logic [1:0] y,
                           input logic d, input logic eop);
    for (int i = 0; i < n; i++) push_exp(NOP, x, y, d, eop);
  endtask

  // one write pass and one read pass over the 4x4 array, x fastest
  task automatic push_march(input logic d);
    for (int k = 0; k < 16; k++) push_exp(WR, 2'(k % 4), 2'(k / 4), d, 1'b0);
    for (int k = 0; k < 16; k++) push_exp(RD, 2'(k % 4), 2'(k / 4), d, 1'b0);
  endtask

  // driver: shift the image in, bit 0 first
  task automatic load_prog();
    for (int i = 0; i < 405; i++) begin
      si = img[i];
      shift_setup = 1'b1;
      @(negedge clk);
    end
    shift_setup = 1'b0;
    si = 1'b0;
  endtask

  // driver: raise run and compare each cycle against the queue
  task automatic run_prog(input string tag);
    logic [15:0] e;
    run = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    last_op = NOP;
  endtask

  task automatic build_repeat_exp();
    push_march(1'b0);
    push_exp(NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    push_march(1'b1);
    push_exp(NOP, 2'd0, 2'd0, 1'b1, 1'b0);
    push_nops(11, 2'd0, 2'd0, 1'b0, 1'b0);
    push_nops(3, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; shift_setup = 1'b0; si = 1'b0; run = 1'b0; last_op = NOP;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_so", 32'(so), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic march
    img = '0;
    img[0*27 +: 27] = mk_inst(WR, AL, 0, INC, CHG, 3'd0, 0, 0, 3'b110, NO_LOOP, 2'd0, 0, 0, 4'd0);
    img[1*27 +: 27] = mk_inst(RD, AL, 0, INC, CHG, 3'd0, 0, 0, 3'b110, NO_LOOP, 2'd0, 0, 0, 4'd0);
    load_prog();
    push_march(1'b0);
    push_nops(12, 2'd0, 2'd0, 1'b0, 1'b0);
    push_nops(3, 2'd0, 2'd0, 1'b0, 1'b1);
    run_prog("march");

    // repeat with inverted data on the second pass
    img[2*27 +: 27] = mk_inst(NOP, AL, 0, KEEP, KEEP, 3'd0, 0, 0, 3'b000, REPEAT, 2'd0, 0, 1, 4'd0);
    load_prog();
    build_repeat_exp();
    run_prog("repeat");

    // scan read-back, recirculating so into si
    check("scan_first_bit", 32'(so), 32'(img[0]));
    for (int i = 0; i < 405; i++) begin
      rb[i] = so;
      si = so;
      shift_setup = 1'b1;
      @(negedge clk);
    end
    shift_setup = 1'b0;
    si = 1'b0;
    for (int s = 0; s < 15; s++) check("scan_slot", 32'(rb[s*27 +: 27]), 32'(img[s*27 +: 27]));
    build_repeat_exp();
    run_prog("repeat_after_scan");

    // repeat-counter loop
    img = '0;
    img[0*27 +: 27] = mk_inst(WR, AL, 0, KEEP, KEEP, 3'd0, 0, 1, 3'b001, NO_LOOP, 2'd0, 0, 0, 4'd0);
    load_prog();
    for (int k = 0; k < 16; k++) push_exp(WR, 2'd0, 2'd0, 1'b0, 1'b0);
    push_nops(13, 2'd0, 2'd0, 1'b0, 1'b0);
    push_nops(2, 2'd0, 2'd0, 1'b0, 1'b1);
    run_prog("rc_loop");

    // x DEC, y CHG, checkerboard inverted, hold address on the last cycle
    img = '0;
    img[0*27 +: 27] = mk_inst(WR, CB, 1, DEC, CHG, 3'd0, 1, 0, 3'b110, NO_LOOP, 2'd0, 0, 0, 4'd0);
    load_prog();
    push_exp(WR, 2'd0, 2'd0, 1'b1, 1'b0);
    for (int y = 1; y < 4; y++)
      for (int x = 3; x >= 0; x--)
        push_exp(WR, 2'(x), 2'(y), logic'(x % 2) ^ logic'(y % 2) ^ 1'b1, 1'b0);
    push_nops(13, 2'd0, 2'd3, 1'b0, 1'b0);
    push_nops(2, 2'd0, 2'd3, 1'b0, 1'b1);
    run_prog("dec_cb");

    // JUMP back to slot 0 until x reaches its end
    img = '0;
    img[0*27 +: 27] = mk_inst(WR, AL, 0, INC, KEEP, 3'd0, 0, 0, 3'b000, NO_LOOP, 2'd0, 0, 0, 4'd0);
    img[1*27 +: 27] = mk_inst(NOP, AL, 0, KEEP, KEEP, 3'd0, 0, 0, 3'b100, JUMP, 2'd0, 0, 0, 4'd0);
    load_prog();
    push_exp(WR, 2'd0, 2'd0, 1'b0, 1'b0);
    push_exp(NOP, 2'd1, 2'd0, 1'b0, 1'b0);
    push_exp(WR, 2'd1, 2'd0, 1'b0, 1'b0);
    push_exp(NOP, 2'd2, 2'd0, 1'b0, 1'b0);
    push_exp(WR, 2'd2, 2'd0, 1'b0, 1'b0);
    push_exp(NOP, 2'd3, 2'd0, 1'b0, 1'b0);
    push_nops(12, 2'd3, 2'd0, 1'b0, 1'b0);
    push_nops(2, 2'd3, 2'd0, 1'b0, 1'b1);
    run_prog("jump");

    // asynchronous reset in the middle of a run
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("midrun_before", 32'(op_cmd), 32'(WR));
    #2 rst = 1'b1;
    #1;
    check("midrun_abort", 32'(obs), 32'd0);
    check("midrun_so", 32'(so), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmbist_ucode_engine.md
# pmbist_ucode_engine

The microcode execution engine of the programmable memory BIST (PMBIST) controller. It holds a scan-loaded 16-entry instruction program, steps the program while `run` is high, and generates memory address, background data and memory control strobes. It sits between the JTAG TDR / run FSM and the memory wrapper. It merges the `microcode_container` and `ctrl_sigs_gen` functions.

## Interface
- `INST_NUM`, 16: program slots; slot 15 is hardwired NOP.
- `ADDR_X`, 2: X address width.
- `ADDR_Y`, 2: Y address width.
- `BG_DATA`, 2: data width.
- `LOOP_NUM`, 4: loop flags.
- `INST_W`, 27: instruction width.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high; clears all state.
- `shift_setup` in 1: shift the program chain one bit.
- `si` in 1: scan-chain input.
- `so` out 1: scan-chain output.
- `run` in 1: execute the program.
- `end_of_prog` out 1: pc == 15 (combinational).
- `op_cmd` out 2: 0 NOP, 1 WRITE, 2 READ.
- `addr_x` out ADDR_X.
- `addr_y` out ADDR_Y.
- `data` out BG_DATA.
- `cs`, `we`, `re`, `oe`, `odd_bwe`, `even_bwe`, `comp_en` out 1 each: memory strobes.

## Operation
- **Instruction fields**, MSB→LSB: op[26:25]; bg_type[24:23] (0 AL, 1 CB, 2 CS, 3 RS); bg_inv[22]; x_cmd[21:20] and y_cmd[19:18] (0 KEEP, 1 CHG, 2 INC, 3 DEC); apply_addr[17:15]; no_last_cnt[14]; rc_inc[13]; cond[12:10] (bit12 AX end, bit11 AY end, bit10 RC end); loop_mode[9:8] (0 NO_LOOP, 1 JUMP, 2 REPEAT, 3 START_LOOP); loop_reg[7:6]; inv_adr_seq[5]; inv_dat_bg[4]; jmp_to[3:0].
- **Program chain**: slots 0..14, 405 bits. When `shift_setup`=1, `si` enters slot 14 bit 26 and every bit moves one position toward slot 0 bit 0. `so` = slot 0 bit 0. Reset clears the chain.
- **Address registers**: two, A and B, each {x,y}.
  - apply_addr A or selAcptoB: output and step A. selAcptoB also copies A→B at the step.
  - B or selBcptoA: output and step B. selBcptoA also copies B→A.
  - AxorB: output A^B and step A.
  - Codes 4, 5 and 7 are reserved and behave as A.
- **Address step**, per axis:
  - INC: +1 mod 2^W. DEC: −1 mod 2^W. KEEP: hold.
  - CHG: +1 only when the other axis wraps in the same cycle. Both axes CHG: hold.
  - When the global `inv_adr` flag is set, INC and DEC swap.
  - Axis end flag = axis at MIN when its effective cmd is DEC, otherwise at MAX.
- **Repeat counter** (RC): 4 bits. Increments each executed cycle when rc_inc=1. RC end = (RC == 15). RC clears when pc changes.
- **Condition met**: AND of the flags selected in cond. cond = 000 counts as met.
- **Cycle where cond is met**: if no_last_cnt=1, the address register holds instead of stepping.
- **pc update** (cond not met means pc holds, unless JUMP):
  - NO_LOOP or START_LOOP: pc+1 when met.
  - JUMP: pc+1 when met, else pc = jmp_to.
  - REPEAT, when met:
    - If loop_flag[loop_reg]=0: set it, toggle `inv_dat` when inv_dat_bg=1, toggle `inv_adr` when inv_adr_seq=1, pc = jmp_to.
    - Otherwise: clear the flag, apply the same toggles again (restoring them), pc+1.
- **Data**:
  - Base pattern: AL = 0s; CS = {x[0]}; RS = {y[0]}; CB = {x[0]^y[0]}, each replicated across BG_DATA.
  - Output = base ^ bg_inv ^ inv_dat, replicated.
- **run=0**: pc, RC, A, B, loop flags, inv_dat and inv_adr all clear synchronously. op_cmd is forced to NOP.
- **Strobes**: decoded combinationally from registered `op_cmd`.
  - WRITE: cs=we=odd_bwe=even_bwe=1.
  - READ: cs=re=oe=1.
  - NOP or op 3: all 0.
  - comp_en = READ delayed one cycle through a register.

## Timing
- op_cmd, addr and data are registered. They show the operation of the instruction at pc in the clock after it executes, i.e. 1-cycle latency from `run` rising.
- One memory operation per clock; no stalls.
- comp_en lags the READ strobes by 1 cycle.
- Reset: all outputs 0, pc = 0, chain = 0.
- `rst` asserted mid-run aborts immediately.
- `end_of_prog` rises when pc reaches 15.
- Shifting during run is undefined; the program must be loaded with run=0.

## Test plan
- **Reset**: assert `rst` → every output 0 and `so`=0.
- **Basic march**: slot0 = WRITE AL, x INC, y CHG, cond AX|AY (110), NO_LOOP; slot1 = same with READ; rest 0. Run → 16 writes, x fastest, data 00, addresses (0,0)..(3,3); then 16 reads with comp_en 1 cycle behind; end_of_prog 13 cycles later.
- **REPEAT**: as the basic march, plus slot2 = NOP REPEAT jmp_to 0 inv_dat_bg → a second pass with data 11; then pass-through; inv_dat ends at 0.
- **RC loop**: WRITE, KEEP/KEEP, rc_inc, cond RC → 16 writes at (0,0), then pc advances.
- **JUMP**: slot1 = NOP, cond AX, JUMP to 0 → loop repeats until x = 3.
- **Scan**: shift 405 bits → `so` emits the first bit shifted in on shift 406; the program reads back unchanged.
